// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_seq_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4
  } seq_state_e;

  // Bit offset of point k inside a flat NFFT*DW bus; point 0 sits in the LSBs.
  // Used both to pack points onto and unpack points from the core-facing buses.
  function automatic int pt_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Frame buffer of NFFT {I,Q} points: serial indexed write, parallel load, serial and parallel read.
// Latency: writes/loads land on the clock edge; both read ports are combinational.
// Backpressure: none; the owner gates wr_en/ld_en.
module fft_frame_buf
  import fft_seq_pkg::*;
#(
  parameter int NFFT = 4,
  parameter int DW   = DW_DEF,
  parameter int IW   = (NFFT > 1) ? $clog2(NFFT) : 1
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [DW-1:0]      wr_i,
  input  logic [DW-1:0]      wr_q,
  input  logic               ld_en,
  input  logic [NFFT*DW-1:0] ld_i,
  input  logic [NFFT*DW-1:0] ld_q,
  input  logic [IW-1:0]      rd_idx,
  output logic [DW-1:0]      rd_i,
  output logic [DW-1:0]      rd_q,
  output logic [NFFT*DW-1:0] par_i,
  output logic [NFFT*DW-1:0] par_q
);

  logic [DW-1:0] mem_i [NFFT];
  logic [DW-1:0] mem_q [NFFT];

  // Storage update: a parallel load takes priority over a serial write (the two users never overlap).
  always_ff @(posedge clk) begin
    if (ld_en) begin
      for (int k = 0; k < NFFT; k++) begin
        mem_i[k] <= ld_i[pt_lsb(k, DW) +: DW];
        mem_q[k] <= ld_q[pt_lsb(k, DW) +: DW];
      end
    end else if (wr_en) begin
      mem_i[wr_idx] <= wr_i;
      mem_q[wr_idx] <= wr_q;
    end
  end

  assign rd_i = mem_i[rd_idx];
  assign rd_q = mem_q[rd_idx];

  for (genvar k = 0; k < NFFT; k++) begin : g_par
    assign par_i[pt_lsb(k, DW) +: DW] = mem_i[k];
    assign par_q[pt_lsb(k, DW) +: DW] = mem_q[k];
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Gathers a serial I/Q stream into NFFT-point frames, runs them through a parallel FFT core, streams results out.
// Latency: last input accepted at T -> fft_valid at T+1; fft_complete at C -> m_valid at C+1; unload NFFT cycles.
// Backpressure: s_ready only in LOAD; output holds each point until m_ready; WAIT aborts after TIMEOUT cycles.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int LOG2_NFFT = 2,
  parameter int DW        = DW_DEF,
  parameter int TIMEOUT   = 1024,
  localparam int NFFT     = 1 << LOG2_NFFT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_i,
  input  logic [DW-1:0]      s_q,
  input  logic               s_last,
  output logic               fft_valid,
  output logic [NFFT*DW-1:0] fft_data_i,
  output logic [NFFT*DW-1:0] fft_data_q,
  input  logic               fft_complete,
  input  logic [NFFT*DW-1:0] fft_res_i,
  input  logic [NFFT*DW-1:0] fft_res_q,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW-1:0]      m_i,
  output logic [DW-1:0]      m_q,
  output logic               m_last,
  output logic [2:0]         state,
  output logic               frame_err,
  output logic               timeout,
  output logic [15:0]        frame_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LOG2_NFFT-1:0] LAST_IDX = LOG2_NFFT'(NFFT - 1);
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT - 1);

  seq_state_e state_q, state_nxt;

  logic [LOG2_NFFT-1:0] wr_idx;
  logic [LOG2_NFFT-1:0] rd_idx;
  logic [TW-1:0]        tmo_cnt;

  logic s_acc, frame_full, frame_short;
  logic res_take, tmo_hit;
  logic m_acc, unload_done;

  logic [NFFT*DW-1:0] ibuf_par_i, ibuf_par_q;
  logic [DW-1:0]      ibuf_rd_i, ibuf_rd_q;
  logic [NFFT*DW-1:0] obuf_par_i, obuf_par_q;
  logic [DW-1:0]      obuf_rd_i, obuf_rd_q;

  assign s_acc       = s_valid && s_ready;
  assign frame_full  = s_acc && (wr_idx == LAST_IDX);
  assign frame_short = s_acc && s_last && (wr_idx != LAST_IDX);
  assign res_take    = (state_q == ST_WAIT) && fft_complete;
  assign tmo_hit     = (state_q == ST_WAIT) && !fft_complete && (tmo_cnt == TMO_LAST);
  assign m_acc       = m_valid && m_ready;
  assign unload_done = m_acc && (rd_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and handshake outputs; a started frame always runs to completion or timeout.
  always_comb begin
    state_nxt = state_q;
    s_ready   = 1'b0;
    fft_valid = 1'b0;
    m_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && (wr_idx == LAST_IDX)) state_nxt = ST_START;
      end
      ST_START: begin
        fft_valid = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (fft_complete)             state_nxt = ST_UNLOAD;
        else if (tmo_cnt == TMO_LAST) state_nxt = ST_IDLE;
      end
      ST_UNLOAD: begin
        m_valid = 1'b1;
        if (m_ready && (rd_idx == LAST_IDX)) state_nxt = enable ? ST_LOAD : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Indices, WAIT watchdog, frame counter and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      tmo_cnt   <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      frame_err <= frame_short;
      timeout   <= tmo_hit;

      if (frame_full || frame_short) wr_idx <= '0;
      else if (s_acc)                wr_idx <= wr_idx + 1'b1;

      if (unload_done) begin
        rd_idx    <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (m_acc) begin
        rd_idx <= rd_idx + 1'b1;
      end

      if ((state_q == ST_WAIT) && !res_take && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      else                                                tmo_cnt <= '0;
    end
  end

  // Core input frame: latched on the edge that accepts the final sample, so it is valid during START.
  // The final sample always lands in point NFFT-1, so it bypasses the buffer write of that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_data_i <= '0;
      fft_data_q <= '0;
    end else if (frame_full) begin
      fft_data_i <= {s_i, ibuf_par_i[(NFFT-1)*DW-1:0]};
      fft_data_q <= {s_q, ibuf_par_q[(NFFT-1)*DW-1:0]};
    end
  end

  fft_frame_buf #(.NFFT(NFFT), .DW(DW), .IW(LOG2_NFFT)) u_ibuf (
    .clk    (clk),
    .wr_en  (s_acc),
    .wr_idx (wr_idx),
    .wr_i   (s_i),
    .wr_q   (s_q),
    .ld_en  (1'b0),
    .ld_i   ('0),
    .ld_q   ('0),
    .rd_idx ('0),
    .rd_i   (ibuf_rd_i),
    .rd_q   (ibuf_rd_q),
    .par_i  (ibuf_par_i),
    .par_q  (ibuf_par_q)
  );

  fft_frame_buf #(.NFFT(NFFT), .DW(DW), .IW(LOG2_NFFT)) u_obuf (
    .clk    (clk),
    .wr_en  (1'b0),
    .wr_idx ('0),
    .wr_i   ('0),
    .wr_q   ('0),
    .ld_en  (res_take),
    .ld_i   (fft_res_i),
    .ld_q   (fft_res_q),
    .rd_idx (rd_idx),
    .rd_i   (obuf_rd_i),
    .rd_q   (obuf_rd_q),
    .par_i  (obuf_par_i),
    .par_q  (obuf_par_q)
  );

  // Only one direction of each buffer is used.
  logic unused_buf_ports;
  assign unused_buf_ports = ^{ibuf_rd_i, ibuf_rd_q, obuf_par_i, obuf_par_q};

  assign m_i    = m_valid ? obuf_rd_i : '0;
  assign m_q    = m_valid ? obuf_rd_q : '0;
  assign m_last = m_valid && (rd_idx == LAST_IDX);
  assign state  = state_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer with an echoing FFT stub and a frame-level reference model.
// Latency: checks fft_valid at T+1, m_valid at C+1, timeout TIMEOUT cycles into WAIT.
// Backpressure: m_ready driven fixed, patterned 1,0,0 or random; input with random gaps.
module tb_fft_frame_sequencer;

  localparam int LOG2_NFFT = 2;
  localparam int NFFT      = 4;
  localparam int DW        = 16;
  localparam int TIMEOUT   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [DW-1:0]      s_i = '0;
  logic [DW-1:0]      s_q = '0;
  logic               s_last = 1'b0;
  logic               fft_valid;
  logic [NFFT*DW-1:0] fft_data_i, fft_data_q;
  logic               fft_complete = 1'b0;
  logic [NFFT*DW-1:0] fft_res_i = '0;
  logic [NFFT*DW-1:0] fft_res_q = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [DW-1:0]      m_i, m_q;
  logic               m_last;
  logic [2:0]         state;
  logic               frame_err, timeout;
  logic [15:0]        frame_cnt;

  fft_frame_sequencer #(.LOG2_NFFT(LOG2_NFFT), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q), .s_last(s_last),
    .fft_valid(fft_valid), .fft_data_i(fft_data_i), .fft_data_q(fft_data_q),
    .fft_complete(fft_complete), .fft_res_i(fft_res_i), .fft_res_q(fft_res_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q), .m_last(m_last),
    .state(state), .frame_err(frame_err), .timeout(timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0]        cur[$];      // samples of the frame being gathered
  logic [31:0]        exp_pts[$];  // points expected at the output, in order
  logic [NFFT*DW-1:0] exp_di, exp_dq;
  logic [31:0]        prev_pt;
  logic [2:0]         st_due;
  int  cyc = 0;
  int  out_pos = 0;
  int  exp_cnt = 0;
  int  exp_tmo_at = -1;
  int  comp_at = -1;
  bit  fv_due = 0, ferr_due = 0, mv_exp = 0, awaiting = 0, st_chk = 0, prev_hold = 0;
  bit  stub_mute = 0;
  int  rdy_mode = 0;
  int  rdy_n = 0;

  task automatic model_reset();
    cur.delete();
    exp_pts.delete();
    out_pos = 0; exp_cnt = 0; exp_tmo_at = -1; comp_at = -1;
    fv_due = 0; ferr_due = 0; mv_exp = 0; awaiting = 0; st_chk = 0; prev_hold = 0;
  endtask

  // Monitor and model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] pt;
    if (rst_n) begin
      chk("fft_valid", 64'(fft_valid), 64'(fv_due));
      chk("frame_err", 64'(frame_err), 64'(ferr_due));
      chk("m_valid", 64'(m_valid), 64'(mv_exp));
      chk("timeout", 64'(timeout), 64'(cyc == exp_tmo_at));
      chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
      if (st_chk) chk("state_after_unload", 64'(state), 64'(st_due));
      if (prev_hold) chk("hold_point", 64'({m_valid, m_i, m_q}), 64'({1'b1, prev_pt}));
      if (cyc == exp_tmo_at) begin
        chk("state_after_timeout", 64'(state), 64'(0));
        repeat (NFFT) if (exp_pts.size() > 0) exp_pts.delete(exp_pts.size() - 1);
        awaiting = 0;
        exp_tmo_at = -1;
      end
      if (fv_due) begin
        chk("fft_data_i", 64'(fft_data_i), 64'(exp_di));
        chk("fft_data_q", 64'(fft_data_q), 64'(exp_dq));
        awaiting = 1;
        if (stub_mute) exp_tmo_at = cyc + TIMEOUT + 1;
        else           comp_at = cyc + 3;
      end
      fv_due = 0; ferr_due = 0; st_chk = 0;

      prev_hold = m_valid && !m_ready;
      prev_pt = {m_i, m_q};
      if (m_valid && m_ready) begin
        if (exp_pts.size() == 0) begin
          chk("spurious_m_point", 64'(m_valid), 64'(0));
        end else begin
          pt = exp_pts.pop_front();
          chk("m_point", 64'({m_i, m_q, m_last}), 64'({pt, out_pos == NFFT - 1}));
          out_pos++;
          if (out_pos == NFFT) begin
            out_pos = 0; exp_cnt++; mv_exp = 0;
            st_chk = 1; st_due = enable ? 3'd1 : 3'd0;
          end
        end
      end
      if (fft_complete && awaiting) begin
        awaiting = 0;
        mv_exp = 1;
      end

      if (s_valid && s_ready) begin
        cur.push_back({s_i, s_q});
        if (cur.size() == NFFT) begin
          for (int k = 0; k < NFFT; k++) begin
            exp_di[k*DW +: DW] = cur[k][31:16];
            exp_dq[k*DW +: DW] = cur[k][15:0];
            exp_pts.push_back(cur[k]);
          end
          cur.delete();
          fv_due = 1;
        end else if (s_last) begin
          cur.delete();
          ferr_due = 1;
        end
      end
      cyc++;
    end
  end

  // FFT stub: echoes the presented frame three cycles after the start pulse; garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (!stub_mute && comp_at == cyc) begin
      fft_complete = 1'b1;
      fft_res_i = fft_data_i;
      fft_res_q = fft_data_q;
    end else begin
      fft_complete = 1'b0;
      fft_res_i = {$urandom, $urandom};
      fft_res_q = {$urandom, $urandom};
    end
  end

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: begin m_ready = (rdy_n % 3 == 0); rdy_n++; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send_pt(input logic [15:0] si, input logic [15:0] sq, input logic last, input bit gap);
    int n;
    bit acc;
    if (gap) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1; s_i = si; s_q = sq; s_last = last;
    n = 0;
    forever begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin chk("s_ready_wait", 64'(s_ready), 64'(1)); break; end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_rand_frame(input bit gap);
    for (int k = 0; k < NFFT; k++) send_pt(16'($urandom), 16'($urandom), k == NFFT - 1, gap);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_pts.size() != 0 || mv_exp || awaiting) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) chk({tag, "_drain"}, 64'(exp_pts.size()), 64'(0));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_data_i"}, 64'(fft_data_i), 64'(0));
    chk({tag, "_data_q"}, 64'(fft_data_q), 64'(0));
    chk({tag, "_ctl"}, 64'({s_ready, fft_valid, m_valid, m_i, m_q, m_last, frame_err, timeout, frame_cnt, state}), 64'(0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_checks("reset");
    rst_n = 1'b1;

    // Directed frame, full-rate unload.
    enable = 1'b1; rdy_mode = 0;
    send_pt(16'd12, 16'd47, 1'b0, 1'b0);
    send_pt(16'd77, 16'd78, 1'b0, 1'b0);
    send_pt(16'd15, 16'd8, 1'b0, 1'b0);
    send_pt(16'hfff7, 16'd5, 1'b1, 1'b0);
    wait_drain("t1");
    chk("t1_frame_cnt", 64'(frame_cnt), 64'(1));

    // Same frame under 1,0,0 backpressure.
    rdy_mode = 1; rdy_n = 0;
    send_pt(16'd12, 16'd47, 1'b0, 1'b0);
    send_pt(16'd77, 16'd78, 1'b0, 1'b0);
    send_pt(16'd15, 16'd8, 1'b0, 1'b0);
    send_pt(16'hfff7, 16'd5, 1'b1, 1'b0);
    wait_drain("t2");
    chk("t2_frame_cnt", 64'(frame_cnt), 64'(2));

    // Early s_last discards a partial frame; the following frame is clean.
    rdy_mode = 2;
    send_pt(16'($urandom), 16'($urandom), 1'b0, 1'b1);
    send_pt(16'($urandom), 16'($urandom), 1'b1, 1'b1);
    send_rand_frame(1'b1);
    wait_drain("t3");
    chk("t3_frame_cnt", 64'(frame_cnt), 64'(3));

    // Core never completes: abort after TIMEOUT cycles in WAIT.
    stub_mute = 1;
    send_rand_frame(1'b0);
    enable = 1'b0;
    repeat (TIMEOUT + 8) begin @(posedge clk); #1; end
    chk("t4_state", 64'(state), 64'(0));
    chk("t4_frame_cnt", 64'(frame_cnt), 64'(3));
    stub_mute = 0;

    // Three frames back to back; enable dropped before the last unload.
    enable = 1'b1;
    send_rand_frame(1'b1);
    send_rand_frame(1'b1);
    send_rand_frame(1'b1);
    enable = 1'b0;
    wait_drain("t5");
    chk("t5_frame_cnt", 64'(frame_cnt), 64'(6));
    chk("t5_state", 64'(state), 64'(0));

    // Asynchronous reset while waiting on the core.
    enable = 1'b1; stub_mute = 1;
    send_rand_frame(1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 rst_checks("midwait_reset");
    model_reset();
    stub_mute = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_rand_frame(1'b1);
    wait_drain("t6");
    chk("t6_frame_cnt", 64'(frame_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequences a parallel NFFT-point FFT core that has a single-pulse `valid` start, a `complete` done flag and parallel I/Q arrays.
- Input side: gathers a serial stream of 16-bit I/Q samples into a frame buffer.
- Core side: presents the full frame to the core with a one-cycle start pulse, waits for `complete` and captures the parallel result.
- Output side: streams the result serially with ready/valid backpressure.
- Placement: between the OFDM sample path and the FFT core; the FFT core is instantiated outside this block.

Parameters:
- LOG2_NFFT, 2, log2 of FFT size.
- NFFT, 1<<LOG2_NFFT, points per frame (derived; do not override).
- DW, 16, signed I/Q sample width.
- TIMEOUT, 1024, maximum cycles to wait for `fft_complete` before abort.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allow new frame loading.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid&&s_ready.
- s_i  in  DW  input sample I.
- s_q  in  DW  input sample Q.
- s_last  in  1  marks last sample of input frame.
- fft_valid  out  1  one-cycle start pulse to FFT core.
- fft_data_i  out  NFFT*DW  frame I, point k at bits [k*DW +: DW].
- fft_data_q  out  NFFT*DW  frame Q, same packing.
- fft_complete  in  1  FFT core result valid.
- fft_res_i  in  NFFT*DW  FFT result I, same packing.
- fft_res_q  in  NFFT*DW  FFT result Q, same packing.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts.
- m_i  out  DW  output sample I.
- m_q  out  DW  output sample Q.
- m_last  out  1  high with output point NFFT-1.
- state  out  3  current FSM state code.
- frame_err  out  1  one-cycle pulse: early s_last, discarded frame.
- timeout  out  1  one-cycle pulse: fft_complete never arrived.
- frame_cnt  out  16  frames fully unloaded, wraps at 2^16.

Behaviour:
- Reset (async on rst_n low, any state): state=IDLE.
  - All of these = 0: s_ready, fft_valid, fft_data_*, m_valid, m_i, m_q, m_last, frame_err, timeout, frame_cnt.
  - Write index, read index and timeout counter = 0. Buffers need not clear.
- State codes: IDLE=0, LOAD=1, START=2, WAIT=3, UNLOAD=4. Codes 5-7 go to IDLE.
- IDLE: s_ready=0. enable=1 → LOAD next cycle.
- LOAD: s_ready=1. Each accepted sample writes ibuf[wr_idx] and increments wr_idx.
  - s_last accepted while wr_idx<NFFT-1 → discard partial frame, wr_idx=0, frame_err pulse, stay LOAD.
  - Sample accepted at wr_idx==NFFT-1 → frame complete regardless of s_last. wr_idx=0, s_ready=0 next cycle, go to START.
  - enable is ignored inside LOAD; a frame in progress always completes.
- START: fft_valid=1 for exactly this cycle.
  - fft_data_i/q are registered from ibuf and held stable from START until the next START.
  - Go to WAIT.
- WAIT: timeout counter increments each cycle.
  - fft_complete=1 → capture fft_res_i/q into obuf in that cycle, clear counter, go to UNLOAD.
  - Counter reaches TIMEOUT-1 without complete → timeout pulse, go to IDLE.
  - fft_complete seen in any other state is ignored.
- UNLOAD: m_valid=1, m_i/m_q=obuf[rd_idx], m_last=(rd_idx==NFFT-1).
  - rd_idx advances only on m_valid&&m_ready. Outputs hold stable while m_ready=0.
  - Last point accepted → rd_idx=0, frame_cnt+1, then next state is LOAD if enable=1, else IDLE.
- Latency:
  - Last input sample accepted at cycle T → fft_valid high at T+1.
  - fft_complete at cycle C → m_valid high at C+1.
  - Full-throughput unload takes NFFT cycles.
- Input stalls: s_valid gaps in LOAD simply pause filling; no timeout applies in LOAD.

Decomposition:
- Package fft_seq_pkg holds:
  - state enum (3-bit codes above);
  - DW default;
  - helper function to pack/unpack point k of a flat NFFT*DW bus.
- One sub-module, fft_frame_buf: NFFT×(2·DW) register array with serial write-index port and parallel read/load port.
  - Instantiated twice: ibuf (serial in, parallel out) and obuf (parallel in, serial out).

Test Plan:
- Frame load: enable=1, stream (12,47),(77,78),(15,8),(-9,5) with s_last on the 4th, m_ready=1; bench stub FFT echoes fft_data 3 cycles after fft_valid → fft_valid one cycle at T+1, m_* emits the same 4 pairs in order, m_last on (-9,5), frame_cnt=1.
- Backpressure: same frame, m_ready toggles 1,0,0,1,… → each point held stable while m_ready=0; exactly 4 handshakes, no duplicate or skipped point.
- Early s_last: s_last on 2nd sample → frame_err pulse, no fft_valid; next 4 samples form a clean frame, frame_cnt increments once.
- Timeout: TIMEOUT=16, stub never asserts complete → timeout pulse 16 cycles after entering WAIT, state=0, m_valid never rises.
- Back-to-back: enable held 1, three frames streamed → state returns LOAD after each unload, frame_cnt=3; enable=0 before the last point → state=0 after.
- Reset mid-WAIT: pull rst_n low asynchronously → all outputs 0 immediately; after release with enable=1 a fresh frame processes normally.
